// File: rtl/node_id_pkg.sv
// Shared types and helpers for the node-name to dense-index allocator.
package node_id_pkg;

  localparam int CHAR_BITS  = 5;
  localparam int NODE_CHARS = 3;
  localparam int NODE_STR_W = NODE_CHARS * CHAR_BITS;
  localparam int NODE_IDX_W = 10;
  localparam logic [7:0] A_CHAR = 8'h61;

  typedef logic [NODE_STR_W-1:0] node_str_t;
  typedef logic [NODE_IDX_W-1:0] node_idx_t;

  typedef struct packed {
    logic      assigned;
    node_idx_t index;
  } lut_entry_t;

  typedef enum logic {CLEAR, RUN} alloc_state_e;

  // Character 0 of the name lands in the least-significant field.
  function automatic node_str_t node_str_from_ascii(input string s);
    node_str_t r;
    r = '0;
    for (int i = 0; i < NODE_CHARS; i++) begin
      if (i < s.len()) r[i*CHAR_BITS +: CHAR_BITS] = CHAR_BITS'(s[i] - A_CHAR);
    end
    return r;
  endfunction

endpackage

// File: rtl/node_lut_ram.sv
// Name-indexed LUT: two async read ports, two write ports and an assigned-bit clear port.
module node_lut_ram
  import node_id_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd0_addr_i,
  output lut_entry_t        rd0_data_o,
  input  logic [ADDR_W-1:0] rd1_addr_i,
  output lut_entry_t        rd1_data_o,
  input  logic              wr0_en_i,
  input  logic [ADDR_W-1:0] wr0_addr_i,
  input  lut_entry_t        wr0_data_i,
  input  logic              wr1_en_i,
  input  logic [ADDR_W-1:0] wr1_addr_i,
  input  lut_entry_t        wr1_data_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i
);

  lut_entry_t mem_q [2**ADDR_W];

  assign rd0_data_o = mem_q[rd0_addr_i];
  assign rd1_data_o = mem_q[rd1_addr_i];

  // Port 0 (src) is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (clr_en_i) mem_q[clr_addr_i].assigned <= 1'b0;
    if (wr1_en_i) mem_q[wr1_addr_i] <= wr1_data_i;
    if (wr0_en_i) mem_q[wr0_addr_i] <= wr0_data_i;
  end

endmodule

// File: rtl/node_id_allocator.sv
// Dual-port node-name to sequential-index allocator with tag capture and LUT clear sweep.
module node_id_allocator #(
  parameter int CHAR_BITS      = 5,
  parameter int NODE_CHARS     = 3,
  parameter int NODE_STR_WIDTH = NODE_CHARS * CHAR_BITS,
  parameter int MAX_NODES      = 1024,
  parameter int NODE_IDX_WIDTH = $clog2(MAX_NODES),
  parameter int NUM_TAGS       = 2,
  // {enc("out"), enc("you")}
  parameter logic [NUM_TAGS-1:0][NODE_STR_WIDTH-1:0] TAG_STRS = {15'd20110, 15'd20952}
) (
  input  logic                                     clk,
  input  logic                                     rst,
  output logic                                     init_done,
  input  logic                                     decoding_done_str,
  input  logic                                     src_node_str_valid,
  input  logic [NODE_STR_WIDTH-1:0]                src_node_str,
  input  logic                                     edge_str_valid,
  input  logic [NODE_STR_WIDTH-1:0]                dst_node_str,
  output logic                                     decoding_done_idx,
  output logic                                     src_node_idx_valid,
  output logic [NODE_IDX_WIDTH-1:0]                src_node_idx,
  output logic                                     edge_idx_valid,
  output logic [NODE_IDX_WIDTH-1:0]                dst_node_idx,
  output logic [NODE_IDX_WIDTH:0]                  node_idx_cnt,
  output logic                                     overflow,
  output logic [NUM_TAGS-1:0]                      tag_valid,
  output logic [NUM_TAGS-1:0][NODE_IDX_WIDTH-1:0]  tag_idx,
  output logic                                     all_tags_valid
);
  import node_id_pkg::*;

  localparam int CNT_W = NODE_IDX_WIDTH + 1;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_NODES);
  localparam logic [NODE_STR_WIDTH-1:0] LAST_ADDR = '1;

  alloc_state_e                            state_q, state_d;
  logic [NODE_STR_WIDTH-1:0]               clr_addr_q, clr_addr_d;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic                                    overflow_q, overflow_d;
  logic                                    src_vld_q, src_vld_d, dst_vld_q, dst_vld_d;
  logic [NODE_IDX_WIDTH-1:0]               src_idx_q, src_idx_d, dst_idx_q, dst_idx_d;
  logic [NUM_TAGS-1:0]                     tag_valid_q, tag_valid_d;
  logic [NUM_TAGS-1:0][NODE_IDX_WIDTH-1:0] tag_idx_q, tag_idx_d;
  logic                                    all_tags_q, dec_done_q;
  logic                                    src_we, dst_we, same_name;
  lut_entry_t                              src_rd, dst_rd, src_wr, dst_wr;

  node_lut_ram #(.ADDR_W(NODE_STR_WIDTH)) u_lut (
    .clk        (clk),
    .rd0_addr_i (src_node_str),
    .rd0_data_o (src_rd),
    .rd1_addr_i (dst_node_str),
    .rd1_data_o (dst_rd),
    .wr0_en_i   (src_we),
    .wr0_addr_i (src_node_str),
    .wr0_data_i (src_wr),
    .wr1_en_i   (dst_we),
    .wr1_addr_i (dst_node_str),
    .wr1_data_i (dst_wr),
    .clr_en_i   (state_q == CLEAR),
    .clr_addr_i (clr_addr_q)
  );

  assign same_name = src_node_str_valid && (src_node_str == dst_node_str);
  assign src_wr    = '{assigned: 1'b1, index: node_idx_t'(src_idx_d)};
  assign dst_wr    = '{assigned: 1'b1, index: node_idx_t'(dst_idx_d)};

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    cnt_d       = cnt_q;
    overflow_d  = overflow_q;
    src_vld_d   = 1'b0;
    dst_vld_d   = 1'b0;
    src_idx_d   = src_idx_q;
    dst_idx_d   = dst_idx_q;
    tag_valid_d = tag_valid_q;
    tag_idx_d   = tag_idx_q;
    src_we      = 1'b0;
    dst_we      = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_ADDR) state_d = RUN;
      end
      RUN: begin
        src_vld_d = src_node_str_valid;
        dst_vld_d = edge_str_valid;
        if (src_node_str_valid) begin
          if (src_rd.assigned) begin
            src_idx_d = src_rd.index[NODE_IDX_WIDTH-1:0];
          end else if (cnt_q < CAP) begin
            src_idx_d = cnt_q[NODE_IDX_WIDTH-1:0];
            src_we    = 1'b1;
            cnt_d     = cnt_q + 1'b1;
          end else begin
            src_idx_d  = '1;
            overflow_d = 1'b1;
          end
        end
        // A same-name miss was already resolved by src; dst just mirrors it.
        if (edge_str_valid) begin
          if (dst_rd.assigned) begin
            dst_idx_d = dst_rd.index[NODE_IDX_WIDTH-1:0];
          end else if (same_name) begin
            dst_idx_d = src_idx_d;
          end else if (cnt_d < CAP) begin
            dst_idx_d = cnt_d[NODE_IDX_WIDTH-1:0];
            dst_we    = 1'b1;
            cnt_d     = cnt_d + 1'b1;
          end else begin
            dst_idx_d  = '1;
            overflow_d = 1'b1;
          end
        end
        for (int t = 0; t < NUM_TAGS; t++) begin
          if (!tag_valid_q[t]) begin
            if (src_node_str_valid && src_node_str == TAG_STRS[t]) begin
              tag_valid_d[t] = 1'b1;
              tag_idx_d[t]   = src_idx_d;
            end else if (edge_str_valid && dst_node_str == TAG_STRS[t]) begin
              tag_valid_d[t] = 1'b1;
              tag_idx_d[t]   = dst_idx_d;
            end
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_addr_q  <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      src_vld_q   <= 1'b0;
      dst_vld_q   <= 1'b0;
      src_idx_q   <= '0;
      dst_idx_q   <= '0;
      tag_valid_q <= '0;
      tag_idx_q   <= '0;
      all_tags_q  <= 1'b0;
      dec_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      src_vld_q   <= src_vld_d;
      dst_vld_q   <= dst_vld_d;
      src_idx_q   <= src_idx_d;
      dst_idx_q   <= dst_idx_d;
      tag_valid_q <= tag_valid_d;
      tag_idx_q   <= tag_idx_d;
      all_tags_q  <= &tag_valid_q;
      dec_done_q  <= (state_q == RUN) && decoding_done_str;
    end
  end

  assign init_done          = (state_q == RUN);
  assign decoding_done_idx  = dec_done_q;
  assign src_node_idx_valid = src_vld_q;
  assign src_node_idx       = src_idx_q;
  assign edge_idx_valid     = dst_vld_q;
  assign dst_node_idx       = dst_idx_q;
  assign node_idx_cnt       = cnt_q;
  assign overflow           = overflow_q;
  assign tag_valid          = tag_valid_q;
  assign tag_idx            = tag_idx_q;
  assign all_tags_valid     = all_tags_q;

endmodule

// File: tb/tb_node_id_allocator.sv
// Directed bench: default-size allocator plus a MAX_NODES=4 instance for capacity cases.
module tb_node_id_allocator;
  import node_id_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-size instance
  logic            dec = 1'b0, src_v = 1'b0, dst_v = 1'b0;
  logic [14:0]     src_s = '0, dst_s = '0;
  logic            init_done, dec_idx, src_iv, dst_iv, ovf, all_tags;
  logic [9:0]      src_i, dst_i;
  logic [10:0]     cnt;
  logic [1:0]      tag_v;
  logic [1:0][9:0] tag_i;

  // MAX_NODES = 4 instance
  logic            s_dec = 1'b0, s_src_v = 1'b0, s_dst_v = 1'b0;
  logic [14:0]     s_src_s = '0, s_dst_s = '0;
  logic            s_init_done, s_dec_idx, s_src_iv, s_dst_iv, s_ovf, s_all_tags;
  logic [1:0]      s_src_i, s_dst_i;
  logic [2:0]      s_cnt;
  logic [1:0]      s_tag_v;
  logic [1:0][1:0] s_tag_i;

  int nvec = 0;
  int nerr = 0;

  node_id_allocator dut (
    .clk(clk), .rst(rst), .init_done(init_done), .decoding_done_str(dec),
    .src_node_str_valid(src_v), .src_node_str(src_s),
    .edge_str_valid(dst_v), .dst_node_str(dst_s),
    .decoding_done_idx(dec_idx), .src_node_idx_valid(src_iv), .src_node_idx(src_i),
    .edge_idx_valid(dst_iv), .dst_node_idx(dst_i), .node_idx_cnt(cnt),
    .overflow(ovf), .tag_valid(tag_v), .tag_idx(tag_i), .all_tags_valid(all_tags)
  );

  node_id_allocator #(.MAX_NODES(4)) dut_s (
    .clk(clk), .rst(rst), .init_done(s_init_done), .decoding_done_str(s_dec),
    .src_node_str_valid(s_src_v), .src_node_str(s_src_s),
    .edge_str_valid(s_dst_v), .dst_node_str(s_dst_s),
    .decoding_done_idx(s_dec_idx), .src_node_idx_valid(s_src_iv), .src_node_idx(s_src_i),
    .edge_idx_valid(s_dst_iv), .dst_node_idx(s_dst_i), .node_idx_cnt(s_cnt),
    .overflow(s_ovf), .tag_valid(s_tag_v), .tag_idx(s_tag_i), .all_tags_valid(s_all_tags)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit sv, input string sn, input bit dv, input string dn);
    @(negedge clk);
    src_v = sv; src_s = node_str_from_ascii(sn);
    dst_v = dv; dst_s = node_str_from_ascii(dn);
    tick();
  endtask

  task automatic sdrive(input bit sv, input string sn, input bit dv, input string dn);
    @(negedge clk);
    s_src_v = sv; s_src_s = node_str_from_ascii(sn);
    s_dst_v = dv; s_dst_s = node_str_from_ascii(dn);
    tick();
  endtask

  task automatic idle();
    @(negedge clk);
    src_v = 1'b0; dst_v = 1'b0; s_src_v = 1'b0; s_dst_v = 1'b0;
  endtask

  // Counts edges from reset release to init_done, pulsing a src valid mid-sweep.
  task automatic wait_init(input string tag);
    int  n;
    bit  saw;
    n = 0; saw = 1'b0;
    @(negedge clk); rst = 1'b0;
    while (!init_done && n < 40000) begin
      tick();
      n++;
      if (src_iv || dst_iv) saw = 1'b1;
      if (n == 100) src_v = 1'b1;
      if (n == 101) src_v = 1'b0;
    end
    nvec++; if (n !== 32768) begin nerr++; $display("FAIL %s init_cycles got %0d want 32768", tag, n); end
    nvec++; if (saw !== 1'b0) begin nerr++; $display("FAIL %s valid_in_clear got %0b want 0", tag, saw); end
    nvec++; if (s_init_done !== 1'b1) begin nerr++; $display("FAIL %s small_init got %0b want 1", tag, s_init_done); end
  endtask

  task automatic test_reset();
    rst = 1'b1; src_v = 1'b1; dec = 1'b1;
    repeat (3) tick();
    nvec++; if (init_done !== 1'b0) begin nerr++; $display("FAIL rst_init_done got %0b want 0", init_done); end
    nvec++; if (src_iv !== 1'b0) begin nerr++; $display("FAIL rst_src_valid got %0b want 0", src_iv); end
    nvec++; if (cnt !== 11'd0) begin nerr++; $display("FAIL rst_cnt got %0d want 0", cnt); end
    nvec++; if ({ovf, tag_v, all_tags, dec_idx} !== 5'b0) begin nerr++; $display("FAIL rst_flags got %b want 00000", {ovf, tag_v, all_tags, dec_idx}); end
    nvec++; if (src_i !== 10'd0) begin nerr++; $display("FAIL rst_src_idx got %0d want 0", src_i); end
    src_v = 1'b0;
    tick();
    nvec++; if (dec_idx !== 1'b0) begin nerr++; $display("FAIL clear_dec_done got %0b want 0", dec_idx); end
    dec = 1'b0;
    wait_init("init");
  endtask

  task automatic test_tags();
    drive(1, "you", 0, "");
    nvec++; if ({src_iv, dst_iv} !== 2'b10) begin nerr++; $display("FAIL you_valids got %b want 10", {src_iv, dst_iv}); end
    nvec++; if (src_i !== 10'd0) begin nerr++; $display("FAIL you_idx got %0d want 0", src_i); end
    nvec++; if (tag_v !== 2'b01) begin nerr++; $display("FAIL you_tag_valid got %b want 01", tag_v); end
    drive(0, "", 1, "out");
    nvec++; if ({src_iv, dst_iv} !== 2'b01) begin nerr++; $display("FAIL out_valids got %b want 01", {src_iv, dst_iv}); end
    nvec++; if (dst_i !== 10'd1) begin nerr++; $display("FAIL out_idx got %0d want 1", dst_i); end
    nvec++; if (cnt !== 11'd2) begin nerr++; $display("FAIL out_cnt got %0d want 2", cnt); end
    nvec++; if (tag_v !== 2'b11) begin nerr++; $display("FAIL out_tag_valid got %b want 11", tag_v); end
    nvec++; if (tag_i !== {10'd1, 10'd0}) begin nerr++; $display("FAIL tag_idx got %h want %h", tag_i, {10'd1, 10'd0}); end
    nvec++; if (all_tags !== 1'b0) begin nerr++; $display("FAIL all_tags_early got %0b want 0", all_tags); end
    idle(); tick();
    nvec++; if (all_tags !== 1'b1) begin nerr++; $display("FAIL all_tags got %0b want 1", all_tags); end
    nvec++; if ({src_iv, dst_iv} !== 2'b00) begin nerr++; $display("FAIL idle_valids got %b want 00", {src_iv, dst_iv}); end
  endtask

  task automatic test_dual();
    drive(1, "aaa", 1, "bbb");
    nvec++; if ({src_i, dst_i} !== {10'd2, 10'd3}) begin nerr++; $display("FAIL dual_new got %0d/%0d want 2/3", src_i, dst_i); end
    nvec++; if (cnt !== 11'd4) begin nerr++; $display("FAIL dual_new_cnt got %0d want 4", cnt); end
    drive(1, "aaa", 1, "aaa");
    nvec++; if ({src_i, dst_i} !== {10'd2, 10'd2}) begin nerr++; $display("FAIL dual_hit got %0d/%0d want 2/2", src_i, dst_i); end
    nvec++; if (cnt !== 11'd4) begin nerr++; $display("FAIL dual_hit_cnt got %0d want 4", cnt); end
    drive(1, "ccc", 1, "ccc");
    nvec++; if ({src_i, dst_i} !== {10'd4, 10'd4}) begin nerr++; $display("FAIL same_new got %0d/%0d want 4/4", src_i, dst_i); end
    nvec++; if (cnt !== 11'd5) begin nerr++; $display("FAIL same_new_cnt got %0d want 5", cnt); end
    idle();
  endtask

  task automatic test_back_to_back();
    drive(1, "ddd", 0, "");
    nvec++; if (src_i !== 10'd5) begin nerr++; $display("FAIL b2b_alloc got %0d want 5", src_i); end
    drive(0, "", 1, "ddd");
    nvec++; if (dst_i !== 10'd5 || cnt !== 11'd6) begin nerr++; $display("FAIL b2b_hit got %0d cnt %0d want 5 cnt 6", dst_i, cnt); end
    drive(1, "aaa", 1, "eee");
    nvec++; if ({src_i, dst_i} !== {10'd2, 10'd6}) begin nerr++; $display("FAIL hit_miss got %0d/%0d want 2/6", src_i, dst_i); end
    nvec++; if (cnt !== 11'd7) begin nerr++; $display("FAIL hit_miss_cnt got %0d want 7", cnt); end
    idle();
    @(negedge clk); dec = 1'b1; tick();
    nvec++; if (dec_idx !== 1'b1) begin nerr++; $display("FAIL dec_done got %0b want 1", dec_idx); end
    @(negedge clk); dec = 1'b0; tick();
    nvec++; if (dec_idx !== 1'b0) begin nerr++; $display("FAIL dec_done_fall got %0b want 0", dec_idx); end
  endtask

  task automatic test_capacity();
    sdrive(1, "aaa", 1, "bbb");
    sdrive(1, "ccc", 1, "ddd");
    nvec++; if ({s_src_i, s_dst_i, s_cnt, s_ovf} !== {2'd2, 2'd3, 3'd4, 1'b0}) begin nerr++; $display("FAIL cap_fill got %0d/%0d cnt %0d ovf %0b want 2/3 cnt 4 ovf 0", s_src_i, s_dst_i, s_cnt, s_ovf); end
    sdrive(1, "eee", 0, "");
    nvec++; if ({s_src_iv, s_src_i} !== {1'b1, 2'b11}) begin nerr++; $display("FAIL cap_refuse got v%0b idx %b want v1 idx 11", s_src_iv, s_src_i); end
    nvec++; if ({s_ovf, s_cnt} !== {1'b1, 3'd4}) begin nerr++; $display("FAIL cap_ovf got ovf %0b cnt %0d want ovf 1 cnt 4", s_ovf, s_cnt); end
    sdrive(0, "", 1, "bbb");
    nvec++; if ({s_dst_i, s_cnt, s_ovf} !== {2'd1, 3'd4, 1'b1}) begin nerr++; $display("FAIL cap_known got %0d cnt %0d ovf %0b want 1 cnt 4 ovf 1", s_dst_i, s_cnt, s_ovf); end
    idle();
  endtask

  task automatic test_rerun();
    drive(1, "fff", 1, "ggg");
    drive(1, "hhh", 0, "");
    nvec++; if ({src_i, cnt} !== {10'd9, 11'd10}) begin nerr++; $display("FAIL ten_alloc got %0d cnt %0d want 9 cnt 10", src_i, cnt); end
    idle();
    rst = 1'b1; tick(); tick();
    nvec++; if ({cnt, tag_v, init_done, s_ovf} !== 15'd0) begin nerr++; $display("FAIL rerun_rst got cnt %0d tags %b init %0b sovf %0b want zeros", cnt, tag_v, init_done, s_ovf); end
    wait_init("reinit");
    drive(1, "aaa", 0, "");
    nvec++; if ({src_i, cnt} !== {10'd0, 11'd1}) begin nerr++; $display("FAIL rerun_aaa got %0d cnt %0d want 0 cnt 1", src_i, cnt); end
    drive(0, "", 1, "you");
    nvec++; if ({dst_i, tag_v} !== {10'd1, 2'b01}) begin nerr++; $display("FAIL rerun_you got %0d tags %b want 1 tags 01", dst_i, tag_v); end
    drive(1, "out", 1, "out");
    nvec++; if ({src_i, dst_i, tag_v, tag_i[1]} !== {10'd2, 10'd2, 2'b11, 10'd2}) begin nerr++; $display("FAIL rerun_out got %0d/%0d tags %b t1 %0d want 2/2 tags 11 t1 2", src_i, dst_i, tag_v, tag_i[1]); end
    nvec++; if ({ovf, cnt} !== {1'b0, 11'd3}) begin nerr++; $display("FAIL rerun_cnt got ovf %0b cnt %0d want ovf 0 cnt 3", ovf, cnt); end
    idle();
  endtask

  task automatic test_cap_edge();
    sdrive(1, "aaa", 1, "bbb");
    sdrive(1, "ccc", 0, "");
    nvec++; if ({s_src_i, s_cnt} !== {2'd2, 3'd3}) begin nerr++; $display("FAIL edge_pre got %0d cnt %0d want 2 cnt 3", s_src_i, s_cnt); end
    sdrive(1, "ddd", 1, "eee");
    nvec++; if ({s_src_i, s_dst_i} !== {2'd3, 2'b11}) begin nerr++; $display("FAIL edge_split got %0d/%b want 3/11", s_src_i, s_dst_i); end
    nvec++; if ({s_ovf, s_cnt, s_dst_iv} !== {1'b1, 3'd4, 1'b1}) begin nerr++; $display("FAIL edge_ovf got ovf %0b cnt %0d v %0b want ovf 1 cnt 4 v 1", s_ovf, s_cnt, s_dst_iv); end
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tags();
    test_dual();
    test_back_to_back();
    test_capacity();
    test_rerun();
    test_cap_edge();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
